// File: rtl/switch_host_port.sv
// ---------------------------------------------------------------------------
// switch_host_port
// Host-side endpoint for one port of the 4-port switch. Local packets are
// buffered in a TX FIFO and launched into the switch input side one per
// cycle, throttled by ip_suspend. Packets from the switch output side are
// filtered on this port's destination bit and buffered in an RX FIFO with
// first-word fall-through delivery. op_suspend back-pressures the switch.
// Four saturating 16-bit statistics counters are kept.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   tx_valid/tx_data    - local packet offer ([3:0] dest mask, [15:4] payload)
//   tx_ready            - TX FIFO not full (combinational from occupancy)
//   rx_valid/rx_data    - RX FIFO head (first-word fall-through)
//   rx_ready            - local consumer accepts rx_data
//   ip_valid/ip_data    - registered packet launch into the switch
//   ip_suspend          - switch input queue full
//   op_valid/op_data    - packet from the switch
//   op_suspend          - registered RX nearly-full back-pressure
//   tx_count, rx_count, drop_count, misroute_count - saturating statistics
// ---------------------------------------------------------------------------
module switch_host_port #(
    parameter int PORT_ID  = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic [15:0] tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [15:0] rx_data,
    input  logic        rx_ready,
    output logic        ip_valid,
    output logic [15:0] ip_data,
    input  logic        ip_suspend,
    input  logic        op_valid,
    input  logic [15:0] op_data,
    output logic        op_suspend,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [15:0] drop_count,
    output logic [15:0] misroute_count
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    // One slot is held back for a packet already in flight from the switch.
    localparam logic [RX_CW-1:0] RX_HIGH = RX_CW'(RX_DEPTH - 1);

    // Saturating add used by every statistics counter.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        sat_add = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0]      r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wr;
    logic [TX_AW-1:0] r_tx_rd;
    logic [TX_CW-1:0] r_tx_cnt;

    logic [15:0]      r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wr;
    logic [RX_AW-1:0] r_rx_rd;
    logic [RX_CW-1:0] r_rx_cnt;

    logic        r_ip_valid;
    logic [15:0] r_ip_data;
    logic        r_op_suspend;
    logic [15:0] r_tx_count;
    logic [15:0] r_rx_count;
    logic [15:0] r_drop_count;
    logic [15:0] r_misroute_count;

    logic             w_tx_accept;
    logic             w_tx_zero;
    logic             w_tx_push;
    logic             w_tx_launch;
    logic             w_rx_pop;
    logic             w_rx_hit;
    logic             w_rx_room;
    logic             w_rx_push;
    logic             w_rx_drop;
    logic             w_misroute;
    logic [1:0]       w_drop_inc;
    logic [RX_CW-1:0] w_rx_cnt_next;

    assign tx_ready    = (r_tx_cnt != TX_FULL);
    assign w_tx_accept = tx_valid && tx_ready;
    // A zero mask would look like an empty ring slot to the switch.
    assign w_tx_zero   = w_tx_accept && (tx_data[3:0] == 4'd0);
    assign w_tx_push   = w_tx_accept && (tx_data[3:0] != 4'd0);
    assign w_tx_launch = (r_tx_cnt != {TX_CW{1'b0}}) && !ip_suspend;

    assign rx_valid   = (r_rx_cnt != {RX_CW{1'b0}});
    assign rx_data    = r_rx_mem[r_rx_rd];
    assign w_rx_pop   = rx_valid && rx_ready;
    assign w_rx_hit   = op_valid && op_data[PORT_ID];
    assign w_misroute = op_valid && !op_data[PORT_ID];
    // A same-cycle pop frees a slot before the push is judged.
    assign w_rx_room  = (r_rx_cnt != RX_FULL) || w_rx_pop;
    assign w_rx_push  = w_rx_hit && w_rx_room;
    assign w_rx_drop  = w_rx_hit && !w_rx_room;

    assign w_drop_inc    = {1'b0, w_tx_zero} + {1'b0, w_rx_drop};
    assign w_rx_cnt_next = r_rx_cnt + RX_CW'(w_rx_push) - RX_CW'(w_rx_pop);

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= tx_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= op_data;
        end
    end

    // TX FIFO pointers/occupancy and the registered launch port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wr    <= {TX_AW{1'b0}};
            r_tx_rd    <= {TX_AW{1'b0}};
            r_tx_cnt   <= {TX_CW{1'b0}};
            r_ip_valid <= 1'b0;
            r_ip_data  <= 16'h0000;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + TX_AW'(1);
            end
            if (w_tx_launch) begin
                r_tx_rd    <= r_tx_rd + TX_AW'(1);
                r_ip_valid <= 1'b1;
                r_ip_data  <= r_tx_mem[r_tx_rd];
            end else begin
                r_ip_valid <= 1'b0;
            end
            r_tx_cnt <= r_tx_cnt + TX_CW'(w_tx_push) - TX_CW'(w_tx_launch);
        end
    end

    // RX FIFO pointers/occupancy and registered back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wr      <= {RX_AW{1'b0}};
            r_rx_rd      <= {RX_AW{1'b0}};
            r_rx_cnt     <= {RX_CW{1'b0}};
            r_op_suspend <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + RX_AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + RX_AW'(1);
            end
            r_rx_cnt     <= w_rx_cnt_next;
            r_op_suspend <= (w_rx_cnt_next >= RX_HIGH);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_count       <= 16'h0000;
            r_rx_count       <= 16'h0000;
            r_drop_count     <= 16'h0000;
            r_misroute_count <= 16'h0000;
        end else begin
            r_tx_count       <= sat_add(r_tx_count, {1'b0, w_tx_launch});
            r_rx_count       <= sat_add(r_rx_count, {1'b0, w_rx_push});
            r_drop_count     <= sat_add(r_drop_count, w_drop_inc);
            r_misroute_count <= sat_add(r_misroute_count, {1'b0, w_misroute});
        end
    end

    assign ip_valid       = r_ip_valid;
    assign ip_data        = r_ip_data;
    assign op_suspend     = r_op_suspend;
    assign tx_count       = r_tx_count;
    assign rx_count       = r_rx_count;
    assign drop_count     = r_drop_count;
    assign misroute_count = r_misroute_count;

endmodule

// File: tb/tb_switch_host_port.sv
// ---------------------------------------------------------------------------
// tb_switch_host_port
// Directed self-checking bench for switch_host_port with PORT_ID=2 and
// 4-entry FIFOs. Inputs change 1ns after a rising edge; outputs are sampled
// at the same point, i.e. after the edge they depend on has settled.
// ---------------------------------------------------------------------------
module tb_switch_host_port;

    logic        clk;
    logic        reset;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        ip_valid;
    logic [15:0] ip_data;
    logic        ip_suspend;
    logic        op_valid;
    logic [15:0] op_data;
    logic        op_suspend;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] drop_count;
    logic [15:0] misroute_count;

    int checks;
    int failures;

    switch_host_port #(.PORT_ID(2), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .ip_valid       (ip_valid),
        .ip_data        (ip_data),
        .ip_suspend     (ip_suspend),
        .op_valid       (op_valid),
        .op_data        (op_data),
        .op_suspend     (op_suspend),
        .tx_count       (tx_count),
        .rx_count       (rx_count),
        .drop_count     (drop_count),
        .misroute_count (misroute_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_valid   = 1'b0;
        tx_data    = 16'h0000;
        rx_ready   = 1'b0;
        ip_suspend = 1'b0;
        op_valid   = 1'b0;
        op_data    = 16'h0000;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL reset_ip_valid got=%0h exp=0", ip_valid); end
        checks++; if (ip_data !== 16'h0000) begin failures++; $display("FAIL reset_ip_data got=%h exp=0000", ip_data); end
        checks++; if (op_suspend !== 1'b0) begin failures++; $display("FAIL reset_op_suspend got=%0h exp=0", op_suspend); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%0h exp=1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0h exp=0", rx_valid); end
        checks++; if ({tx_count, rx_count, drop_count, misroute_count} !== 64'd0) begin
            failures++; $display("FAIL reset_counters got=%h/%h/%h/%h exp=0", tx_count, rx_count, drop_count, misroute_count);
        end
    endtask

    task automatic test_tx_single();
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 16'h1232;
        step();
        tx_valid = 1'b0;
        checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL tx1_early got=%0h exp=0", ip_valid); end
        step();
        checks++; if (ip_valid !== 1'b1) begin failures++; $display("FAIL tx1_valid got=%0h exp=1", ip_valid); end
        checks++; if (ip_data !== 16'h1232) begin failures++; $display("FAIL tx1_data got=%h exp=1232", ip_data); end
        checks++; if (tx_count !== 16'd1) begin failures++; $display("FAIL tx1_count got=%0d exp=1", tx_count); end
        step();
        checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL tx1_pulse_end got=%0h exp=0", ip_valid); end
        checks++; if (ip_data !== 16'h1232) begin failures++; $display("FAIL tx1_data_hold got=%h exp=1232", ip_data); end
    endtask

    task automatic test_tx_suspend();
        logic [15:0] pkt [6];
        pkt[0] = 16'h1111; pkt[1] = 16'h2221; pkt[2] = 16'h3331;
        pkt[3] = 16'h4441; pkt[4] = 16'h5551; pkt[5] = 16'h6661;
        do_reset();
        ip_suspend = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1'b1;
            tx_data  = pkt[i];
            checks++; if (tx_ready !== (i < 4)) begin failures++; $display("FAIL susp_tx_ready[%0d] got=%0h exp=%0h", i, tx_ready, (i < 4)); end
            step();
            checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL susp_no_launch[%0d] got=%0h exp=0", i, ip_valid); end
        end
        tx_valid   = 1'b0;
        ip_suspend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (ip_valid !== 1'b1) begin failures++; $display("FAIL susp_drain_valid[%0d] got=%0h exp=1", i, ip_valid); end
            checks++; if (ip_data !== pkt[i]) begin failures++; $display("FAIL susp_drain_data[%0d] got=%h exp=%h", i, ip_data, pkt[i]); end
        end
        step();
        checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL susp_drain_end got=%0h exp=0", ip_valid); end
        checks++; if (tx_count !== 16'd4) begin failures++; $display("FAIL susp_tx_count got=%0d exp=4", tx_count); end
    endtask

    task automatic test_tx_zero_mask();
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 16'hABC0;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL zero_no_launch[%0d] got=%0h exp=0", i, ip_valid); end
        end
        checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL zero_drop_count got=%0d exp=1", drop_count); end
        checks++; if (tx_count !== 16'd0) begin failures++; $display("FAIL zero_tx_count got=%0d exp=0", tx_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pkt [3];
        pkt[0] = 16'hA012; pkt[1] = 16'hB024; pkt[2] = 16'hC038;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_valid = (i < 3);
            tx_data  = (i < 3) ? pkt[i % 3] : 16'h0000;
            step();
            if (i > 0) begin
                checks++; if (ip_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, ip_valid); end
                checks++; if (ip_data !== pkt[i-1]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, ip_data, pkt[i-1]); end
            end
        end
        tx_valid = 1'b0;
        checks++; if (tx_count !== 16'd3) begin failures++; $display("FAIL b2b_tx_count got=%0d exp=3", tx_count); end
    endtask

    task automatic test_rx_route();
        do_reset();
        op_valid = 1'b1;
        op_data  = 16'h5554;
        step();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL route_rx_valid got=%0h exp=1", rx_valid); end
        checks++; if (rx_data !== 16'h5554) begin failures++; $display("FAIL route_rx_data got=%h exp=5554", rx_data); end
        op_data = 16'h5551;
        step();
        op_valid = 1'b0;
        checks++; if (misroute_count !== 16'd1) begin failures++; $display("FAIL route_misroute got=%0d exp=1", misroute_count); end
        checks++; if (rx_count !== 16'd1) begin failures++; $display("FAIL route_rx_count got=%0d exp=1", rx_count); end
        checks++; if (rx_data !== 16'h5554) begin failures++; $display("FAIL route_head_kept got=%h exp=5554", rx_data); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL route_popped got=%0h exp=0", rx_valid); end
    endtask

    task automatic test_rx_backpressure();
        logic [15:0] pkt [5];
        pkt[0] = 16'h1114; pkt[1] = 16'h2224; pkt[2] = 16'h3334;
        pkt[3] = 16'h4444; pkt[4] = 16'h5554;
        do_reset();
        op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_data = pkt[i];
            step();
            checks++; if (op_suspend !== (i >= 2)) begin failures++; $display("FAIL bp_suspend[%0d] got=%0h exp=%0h", i, op_suspend, (i >= 2)); end
        end
        checks++; if (rx_count !== 16'd4) begin failures++; $display("FAIL bp_rx_count got=%0d exp=4", rx_count); end
        checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL bp_drop_count got=%0d exp=1", drop_count); end
        // RX overflow and TX zero-mask drop in the same cycle add two.
        op_data  = 16'h6664;
        tx_valid = 1'b1;
        tx_data  = 16'h7770;
        step();
        op_valid = 1'b0;
        tx_valid = 1'b0;
        checks++; if (drop_count !== 16'd3) begin failures++; $display("FAIL bp_double_drop got=%0d exp=3", drop_count); end
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid[%0d] got=%0h exp=1", k, rx_valid); end
            checks++; if (rx_data !== pkt[k]) begin failures++; $display("FAIL bp_drain_data[%0d] got=%h exp=%h", k, rx_data, pkt[k]); end
            step();
            checks++; if (op_suspend !== (k == 0)) begin failures++; $display("FAIL bp_drain_suspend[%0d] got=%0h exp=%0h", k, op_suspend, (k == 0)); end
        end
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0h exp=0", rx_valid); end
    endtask

    task automatic test_reset_flush();
        do_reset();
        ip_suspend = 1'b1;
        op_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_valid = (i < 2);
            tx_data  = 16'h0A01 + 16'h0100 * 16'(i);
            op_data  = 16'h0C04 + 16'h0100 * 16'(i);
            step();
        end
        tx_valid = 1'b0;
        op_valid = 1'b0;
        checks++; if (op_suspend !== 1'b1) begin failures++; $display("FAIL flush_pre_suspend got=%0h exp=1", op_suspend); end
        reset      = 1'b1;
        ip_suspend = 1'b0;
        step();
        reset = 1'b0;
        checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL flush_ip_valid got=%0h exp=0", ip_valid); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL flush_rx_valid got=%0h exp=0", rx_valid); end
        checks++; if (op_suspend !== 1'b0) begin failures++; $display("FAIL flush_op_suspend got=%0h exp=0", op_suspend); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL flush_tx_ready got=%0h exp=1", tx_ready); end
        checks++; if ({tx_count, rx_count, drop_count, misroute_count} !== 64'd0) begin
            failures++; $display("FAIL flush_counters got=%h/%h/%h/%h exp=0", tx_count, rx_count, drop_count, misroute_count);
        end
        step();
        checks++; if (ip_valid !== 1'b0) begin failures++; $display("FAIL flush_no_launch got=%0h exp=0", ip_valid); end
        checks++; if (tx_count !== 16'd0) begin failures++; $display("FAIL flush_tx_count got=%0d exp=0", tx_count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tx_single();
        test_tx_suspend();
        test_tx_zero_mask();
        test_back_to_back();
        test_rx_route();
        test_rx_backpressure();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
